// File: rtl/lut_neuron_pkg.sv
// Shared types and sizing helpers for the programmable truth-table neuron.
package lut_neuron_pkg;

    typedef enum logic [1:0] {
        UNPROG = 2'd0,
        LOAD   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    // Number of config words needed to fill the whole table.
    function automatic int nwords(input int in_bits, input int out_bits, input int cfg_w);
        return ((1 << in_bits) * out_bits) / cfg_w;
    endfunction

    // Address width for n words, never below one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lut_table_store.sv
// Table register array: word-wide write port, entry-wide combinational read port.
// Optional registered word readback when LUT_NEURON_READBACK_EN is defined.
module lut_table_store
    import lut_neuron_pkg::*;
#(
    parameter  int IN_BITS  = 8,
    parameter  int OUT_BITS = 1,
    parameter  int CFG_W    = 8,
    localparam int NWORDS   = nwords(IN_BITS, OUT_BITS, CFG_W),
    localparam int PW       = ptr_w(NWORDS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [PW-1:0]       wr_addr,
    input  logic [CFG_W-1:0]    wr_data,
    input  logic [IN_BITS-1:0]  rd_idx,
    output logic [OUT_BITS-1:0] rd_data
`ifdef LUT_NEURON_READBACK_EN
    ,
    input  logic [PW-1:0]       rb_addr,
    output logic [CFG_W-1:0]    rb_data
`endif
);

    logic [CFG_W-1:0]           words [NWORDS];
    logic [NWORDS*CFG_W-1:0]    tbl_flat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NWORDS; i++) words[i] <= '0;
        end else if (wr_en) begin
            words[wr_addr] <= wr_data;
        end
    end

    // Flat view so entry i sits at bits [i*OUT_BITS +: OUT_BITS].
    for (genvar w = 0; w < NWORDS; w++) begin : g_flat
        assign tbl_flat[w*CFG_W +: CFG_W] = words[w];
    end

    assign rd_data = tbl_flat[rd_idx*OUT_BITS +: OUT_BITS];

`ifdef LUT_NEURON_READBACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      rb_data <= '0;
        else if (int'(rb_addr) < NWORDS) rb_data <= words[rb_addr];
        else                             rb_data <= '0;
    end
`endif

endmodule

// File: rtl/lut_neuron_prog.sv
// Runtime-programmable LUT neuron: serial table load, then 1-cycle valid/ready inference.
// Define LUT_NEURON_READBACK_EN to add the rb_addr/rb_data table readback port.
module lut_neuron_prog
    import lut_neuron_pkg::*;
#(
    parameter  int IN_BITS  = 8,
    parameter  int OUT_BITS = 1,
    parameter  int CFG_W    = 8,
    localparam int NWORDS   = nwords(IN_BITS, OUT_BITS, CFG_W),
    localparam int PW       = ptr_w(NWORDS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CFG_W-1:0]    cfg_data,
    output logic                cfg_done,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_data
`ifdef LUT_NEURON_READBACK_EN
    ,
    input  logic [PW-1:0]       rb_addr,
    output logic [CFG_W-1:0]    rb_data
`endif
);

    state_t                state, state_nx;
    logic [PW-1:0]         ptr;
    logic                  last_word;
    logic                  cfg_hs, in_hs;
    logic [OUT_BITS-1:0]   rd_data;

    assign last_word = (ptr == PW'(NWORDS - 1));
    assign cfg_hs    = cfg_valid && cfg_ready;
    assign in_hs     = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= UNPROG;
        else        state <= state_nx;
    end

    // cfg_start always wins: it blocks both handshakes in the same cycle.
    always_comb begin
        state_nx  = state;
        cfg_ready = 1'b0;
        in_ready  = 1'b0;
        case (state)
            UNPROG: begin
                if (cfg_start) state_nx = LOAD;
            end
            LOAD: begin
                cfg_ready = !cfg_start;
                if (cfg_start)                     state_nx = LOAD;
                else if (cfg_valid && last_word)   state_nx = ACTIVE;
            end
            ACTIVE: begin
                in_ready = !cfg_start && (!out_valid || out_ready);
                if (cfg_start) state_nx = LOAD;
            end
            default: state_nx = UNPROG;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= cfg_hs && last_word;
            if (cfg_start)                 ptr <= '0;
            else if (cfg_hs && !last_word) ptr <= ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_hs) begin
            out_valid <= 1'b1;
            out_data  <= rd_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    lut_table_store #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS),
        .CFG_W    (CFG_W)
    ) u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (cfg_hs),
        .wr_addr (ptr),
        .wr_data (cfg_data),
        .rd_idx  (in_data),
        .rd_data (rd_data)
`ifdef LUT_NEURON_READBACK_EN
        ,
        .rb_addr (rb_addr),
        .rb_data (rb_data)
`endif
    );

endmodule

// File: tb/tb_lut_neuron_prog.sv
// Scoreboard bench for lut_neuron_prog: stimulus pushes expected results, a monitor pops them.
module tb_lut_neuron_prog;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_start, cfg_valid, cfg_ready, cfg_done;
    logic [7:0] cfg_data;
    logic       in_valid, in_ready;
    logic [7:0] in_data;
    logic       out_valid, out_ready;
    logic [0:0] out_data;
`ifdef LUT_NEURON_READBACK_EN
    logic [4:0] rb_addr;
    logic [7:0] rb_data;
`endif

    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    int   n_sent  = 0;
    int   n_rcvd  = 0;
    int   n_done  = 0;
    int   exp_done = 0;
    logic exp_q[$];
    logic prev_stall = 1'b0;
    logic [0:0] held;

    lut_neuron_prog dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_data  (cfg_data),
        .cfg_done  (cfg_done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef LUT_NEURON_READBACK_EN
        ,
        .rb_addr   (rb_addr),
        .rb_data   (rb_data)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: scoreboard pop on each output handshake, plus stall stability and cfg_done count.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg_done) n_done++;
            if (out_valid && prev_stall) chk("stall_stable", 32'(out_data), 32'(held));
            if (out_valid && out_ready) begin
                n_rcvd++;
                if (exp_q.size() == 0) chk("unexpected_result", 32'(out_data), 32'hDEAD);
                else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
            prev_stall = out_valid && !out_ready;
            held       = out_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic start_cfg;
        cfg_start = 1'b1;
        tick;
        cfg_start = 1'b0;
    endtask

    // Load n words from pointer 0; incr selects word k = k instead of a constant.
    task automatic load(input int n, input logic [7:0] val, input bit incr);
        for (int k = 0; k < n; k++) begin
            cfg_valid = 1'b1;
            cfg_data  = incr ? 8'(k) : val;
            @(negedge clk);
            chk("cfg_ready_load", 32'(cfg_ready), 32'd1);
            chk("in_ready_load", 32'(in_ready), 32'd0);
            tick;
        end
        cfg_valid = 1'b0;
        if (n == 32) begin
            exp_done++;
            @(negedge clk);
            chk("cfg_done_pulse", 32'(cfg_done), 32'd1);
            chk("in_ready_active", 32'(in_ready), 32'd1);
            tick;
            @(negedge clk);
            chk("cfg_done_once", 32'(cfg_done), 32'd0);
            tick;
        end
    endtask

    task automatic send(input logic [7:0] idx, input logic exp);
        int n = 0;
        in_valid = 1'b1;
        in_data  = idx;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        else begin
            exp_q.push_back(exp);
            n_sent++;
        end
        tick;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst_n = 1'b0; cfg_start = 0; cfg_valid = 0; cfg_data = 0;
        in_valid = 0; in_data = 0; out_ready = 1'b1;
`ifdef LUT_NEURON_READBACK_EN
        rb_addr = '0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("rst_cfg_done", 32'(cfg_done), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        tick;
        rst_n = 1'b1;

        // Unprogrammed: requests are refused.
        in_valid = 1'b1; in_data = 8'h05;
        repeat (10) begin
            @(negedge clk);
            chk("unprog_in_ready", 32'(in_ready), 32'd0);
            chk("unprog_out_valid", 32'(out_valid), 32'd0);
        end
        tick;
        in_valid = 1'b0;
        start_cfg;
        @(negedge clk);
        chk("cfg_ready_after_start", 32'(cfg_ready), 32'd1);
        tick;

        // 0xAA everywhere: odd indices are 1.
        load(32, 8'hAA, 1'b0);
        send(8'h05, 1'b1);
        send(8'h04, 1'b0);
        send(8'hFF, 1'b1);

        // Backpressure mid-stream.
        fork
            for (int i = 0; i < 16; i++) send(8'(i), i[0]);
            begin
                repeat (6) tick;
                out_ready = 1'b0;
                repeat (3) tick;
                out_ready = 1'b1;
            end
        join
        t0 = cyc;
        for (int i = 16; i < 24; i++) send(8'(i), i[0]);
        chk("throughput_cycles", 32'(cyc - t0), 32'd8);
        repeat (3) tick;

        // Restart mid-load; the word sent with cfg_start is refused.
        start_cfg;
        load(10, 8'hFF, 1'b0);
        cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'h00;
        @(negedge clk);
        chk("start_blocks_word", 32'(cfg_ready), 32'd0);
        tick;
        cfg_start = 1'b0; cfg_valid = 1'b0;
        load(32, 8'h0F, 1'b0);
        send(8'h04, 1'b0);
        send(8'h03, 1'b1);
        repeat (2) tick;

        // Async reset in the middle of a load.
        start_cfg;
        load(21, 8'hFF, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_cfg_ready", 32'(cfg_ready), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_cfg_done", 32'(cfg_done), 32'd0);
        tick;
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 8'h03;
        repeat (5) begin
            @(negedge clk);
            chk("post_arst_in_ready", 32'(in_ready), 32'd0);
        end
        tick;
        in_valid = 1'b0;
        start_cfg;
        load(32, 8'h0F, 1'b0);
        send(8'h03, 1'b1);
        send(8'h07, 1'b0);
        repeat (2) tick;

`ifdef LUT_NEURON_READBACK_EN
        start_cfg;
        load(32, 8'h00, 1'b1);
        rb_addr = 5'd17;
        tick;
        @(negedge clk);
        chk("readback_17", 32'(rb_data), 32'h11);
        tick;
`endif

        repeat (4) tick;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("result_count", 32'(n_rcvd), 32'(n_sent));
        chk("cfg_done_count", 32'(n_done), 32'(exp_done));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
